ari_shift_right_seq: RTL and testbench
======================================

# ari_shift_right_seq

Sequential arithmetic shift-right unit for the ALU datapath; the right-direction counterpart of the combinational arithmetic shift-left.
- Sign-extends operand `a` right by `b` positions, one bit per clock, under a start/done handshake.
- Reports through `cout` whether any nonzero bit was shifted out (loss of precision).
- Sits beside the other ALU operation units; the ALU mux consumes `s`/`cout` when `done` pulses.

## Interface
- WIDTH, 16, operand/result width; shift counter is clog2(WIDTH)+1 bits
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand, sampled with start
- b  input  WIDTH  shift amount, sampled with start; unsigned
- s  output  WIDTH  result register; valid when done=1, held until next accepted start
- cout  output  1  sticky OR of every bit shifted out
- busy  output  1  high in SHIFT
- done  output  1  one-cycle pulse, high in DONE

## Operation
- Effective shift n = min(b, WIDTH); b ≥ WIDTH always gives all sign bits.
- States:
  - IDLE: waits for start.
  - SHIFT: performs the shifts; start ignored, a/b changes ignored.
  - DONE: lasts exactly one cycle, then IDLE. start in DONE is accepted (back-to-back) and takes the same transition as start in IDLE.
- Accept edge (start=1 in IDLE/DONE):
  - data←a, cnt←n, cout←0.
  - Next state: DONE if n=0, else SHIFT.
- Each SHIFT edge:
  - data←{data[W-1], data[W-1:1]}; cout←cout | data[0]; cnt←cnt−1.
  - Next state: DONE when cnt=1, else stay in SHIFT.
- s reflects data; holds its value in IDLE.
- Reset (any time, including mid-SHIFT): state=IDLE, s=0, cout=0, busy=0, done=0, cnt=0; the in-flight operation is discarded.

## Timing
- Latency: done high n+1 rising edges after the accept edge is sampled (1 for n=0, WIDTH+1 for b ≥ WIDTH).
- Throughput: back-to-back starts issued in the DONE cycle give one result per n+1 cycles.
- Outputs are all registered; no combinational path from inputs to outputs.
- start held high continuously: a new operation is accepted in every DONE cycle.

## Configuration
- ARI_SHIFT_ROUND_EN defined:
  - On the final SHIFT edge, data←shifted value + last bit shifted out (round half up), modulo 2^WIDTH.
  - n=0: no rounding.
  - Negative operand with n=WIDTH rounds to 0.
  - cout semantics unchanged.
- Undefined: pure truncation (floor), identical to the arithmetic `>>>`.

## Structure
- Package ari_shift_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - default width constant 16;
  - shift-amount saturation function min(b, WIDTH).
- One sub-module, ari_sra_step: combinational one-bit arithmetic right step returning {shifted data, bit out}. The FSM/counter stays in the top module.

## Test plan
- a=0x8000, b=3, start one cycle → done after 4 edges; s=0xF000, cout=0; busy high for 3 cycles.
- a=0x0007, b=2 → s=0x0001, cout=1 (with ARI_SHIFT_ROUND_EN: s=0x0002).
- a=0x1234, b=0 → done after 1 edge, s=0x1234, cout=0, busy never high.
- a=0xA5A5, b=40 → done after 17 edges, s=0xFFFF, cout=1 (with ARI_SHIFT_ROUND_EN: s=0x0000).
- Reset mid-operation: a=0x4000, b=10, rst_n low 4 edges after accept → s=0, busy=0, done=0 immediately. After release, a=0x4000, b=1 → s=0x2000 after 2 edges.
- start pulsed during SHIFT with different a/b → ignored, result unchanged. Back-to-back: start in the DONE cycle with a=0xFFF0, b=4 → next done after 5 edges, s=0xFFFF, cout=0.

Source files
------------

// File: rtl/ari_shift_pkg.sv
// Shared types and helpers for the sequential arithmetic shift-right unit.
package ari_shift_pkg;

    localparam int unsigned ARI_SHIFT_DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ari_shift_state_e;

    // Effective shift amount: min(amt, width).
    function automatic int unsigned sat_shift(input logic [63:0] amt, input int unsigned width);
        if (amt >= 64'(width)) begin
            return width;
        end
        return 32'(amt);
    endfunction

endpackage

// File: rtl/ari_sra_step.sv
// One-bit arithmetic right step: sign bit replicated, LSB reported as bit_out.
module ari_sra_step
    import ari_shift_pkg::*;
#(
    parameter int unsigned WIDTH = ARI_SHIFT_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             bit_out
);

    assign q       = {d[WIDTH-1], d[WIDTH-1:1]};
    assign bit_out = d[0];

endmodule

// File: rtl/ari_shift_right_seq.sv
// Sequential arithmetic shift-right, one bit per clock, start/done handshake.
// Optional round-half-up on the final step when ARI_SHIFT_ROUND_EN is defined.
module ari_shift_right_seq
    import ari_shift_pkg::*;
#(
    parameter int unsigned WIDTH = ARI_SHIFT_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    ari_shift_state_e state_q, state_d;
    logic [WIDTH-1:0] data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] amt_c;
    logic             cout_d;
    logic             busy_d;
    logic             done_d;
    logic [WIDTH-1:0] step_q_c;
    logic             step_out_c;

    ari_sra_step #(.WIDTH(WIDTH)) u_step (
        .d       (s),
        .q       (step_q_c),
        .bit_out (step_out_c)
    );

    assign amt_c = CNT_W'(sat_shift(64'(b), WIDTH));

    // Next-state and next-output logic; s doubles as the working data register.
    always_comb begin
        state_d = state_q;
        data_d  = s;
        cnt_d   = cnt_q;
        cout_d  = cout;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    data_d  = a;
                    cnt_d   = amt_c;
                    cout_d  = 1'b0;
                    state_d = (amt_c == '0) ? DONE : SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                data_d = step_q_c;
`ifdef ARI_SHIFT_ROUND_EN
                if (cnt_q == CNT_W'(1)) begin
                    data_d = step_q_c + WIDTH'(step_out_c);
                end
`endif
                cout_d = cout | step_out_c;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s       <= '0;
            cnt_q   <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            s       <= data_d;
            cnt_q   <= cnt_d;
            cout    <= cout_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_ari_shift_right_seq.sv
// Directed self-checking bench for ari_shift_right_seq (honours ARI_SHIFT_ROUND_EN).
module tb_ari_shift_right_seq;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         cout;
    logic         busy;
    logic         done;

    int n_checks;
    int n_fail;
    int edges;
    int busy_cnt;

    ari_shift_right_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .s     (s),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges (accept edge included) until done, with a bound.
    task automatic wait_done(input int init_edges, output int n_edges, output int n_busy);
        n_edges = init_edges;
        n_busy  = int'(busy);
        while (!done && n_edges < 40) begin
            step();
            n_edges++;
            if (busy) n_busy++;
        end
        if (!done) chk("timeout_done", 32'(done), 32'd1);
    endtask

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int n_edges, output int n_busy);
        a     = av;
        b     = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(1, n_edges, n_busy);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        step();
        step();
        chk("rst_s", 32'(s), 32'h0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();

        // Negative operand, small shift
        issue(16'h8000, 16'd3, edges, busy_cnt);
        chk("t1_edges", 32'(edges), 32'd4);
        chk("t1_s", 32'(s), 32'hF000);
        chk("t1_cout", 32'(cout), 32'd0);
        chk("t1_busy", 32'(busy_cnt), 32'd3);
        step();
        chk("t1_done_pulse", 32'(done), 32'd0);

        // Loss of precision
        issue(16'h0007, 16'd2, edges, busy_cnt);
        chk("t2_edges", 32'(edges), 32'd3);
`ifdef ARI_SHIFT_ROUND_EN
        chk("t2_s", 32'(s), 32'h0002);
`else
        chk("t2_s", 32'(s), 32'h0001);
`endif
        chk("t2_cout", 32'(cout), 32'd1);
        step();

        // Zero shift
        issue(16'h1234, 16'd0, edges, busy_cnt);
        chk("t3_edges", 32'(edges), 32'd1);
        chk("t3_s", 32'(s), 32'h1234);
        chk("t3_cout", 32'(cout), 32'd0);
        chk("t3_busy", 32'(busy_cnt), 32'd0);
        a = 16'hDEAD;
        step();
        step();
        chk("t3_hold", 32'(s), 32'h1234);

        // Saturated shift amount
        issue(16'hA5A5, 16'd40, edges, busy_cnt);
        chk("t4_edges", 32'(edges), 32'd17);
`ifdef ARI_SHIFT_ROUND_EN
        chk("t4_s", 32'(s), 32'h0000);
`else
        chk("t4_s", 32'(s), 32'hFFFF);
`endif
        chk("t4_cout", 32'(cout), 32'd1);
        step();

        // Reset mid-operation
        a     = 16'h4000;
        b     = 16'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_s", 32'(s), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_cout", 32'(cout), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        issue(16'h4000, 16'd1, edges, busy_cnt);
        chk("t5_edges", 32'(edges), 32'd2);
        chk("t5_s", 32'(s), 32'h2000);
        step();

        // start during SHIFT is ignored, then back-to-back start in DONE
        a     = 16'h0100;
        b     = 16'd4;
        start = 1'b1;
        step();
        a     = 16'hFFFF;
        b     = 16'd1;
        step();
        start = 1'b0;
        wait_done(2, edges, busy_cnt);
        chk("t6_edges", 32'(edges), 32'd5);
        chk("t6_s", 32'(s), 32'h0010);
        chk("t6_cout", 32'(cout), 32'd0);
        issue(16'hFFF0, 16'd4, edges, busy_cnt);
        chk("t7_edges", 32'(edges), 32'd5);
        chk("t7_s", 32'(s), 32'hFFFF);
        chk("t7_cout", 32'(cout), 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
